register_bank: RTL

- Multi-channel successor to the single async-strobe register emulator.
- Holds CHANNELS independent WIDTH-bit registers. Each register is written by its own asynchronous write strobe and has its own set and reset overrides.
- All state lives in the `clock` domain and updates on the falling edge of `clock`.
- Used wherever the original chip has banks of latches clocked by bus strobes (MMU/DMA/video address registers). Adds edge polarity, latch mode, optional strobe synchroniser and a per-channel update pulse.

---
 rtl/register_bank.sv | 121 ++++++++++++
 1 files changed

// File: rtl/register_bank.sv
// register_bank: CHANNELS independent WIDTH-bit registers, each loaded by its
// own write strobe that is asynchronous to the clock, with per-channel set and
// reset overrides. All state updates on the falling edge of clock.
//
// Per channel:
//   - The strobe is sampled on every negedge, optionally through one extra
//     sampling stage (SYNC=1) to reduce metastability exposure.
//   - MODE=0 captures d on an inactive-to-active strobe transition.
//     MODE=1 loads d on every negedge while the strobe is at its active level.
//   - q is combinational: reset override wins, then set override, then the
//     stored value. An override held across a negedge is written back into
//     the stored value, so it persists after release (matching the original
//     async set/reset latch behaviour).
//   - upd pulses for one clock period at the negedge that starts a capture.
//
// There is no handshake on this block: upd is an informational pulse and
// there is no back-pressure. A consumer that treats upd as "valid" sees
// q already holding the newly loaded value (unless an override masks it)
// for the whole period that upd is high.
module register_bank #(
    parameter int          WIDTH     = 8,
    parameter int          CHANNELS  = 4,
    parameter int unsigned SET_VALUE = 1,
    parameter int          EDGE      = 1,
    parameter int          MODE      = 0,
    parameter int          SYNC      = 0
) (
    input  logic                      clock,
    input  logic                      resb,
    input  logic [CHANNELS-1:0]       s,
    input  logic [CHANNELS-1:0]       r,
    input  logic [CHANNELS-1:0]       c,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       upd
);

    // Active strobe level: 1 = rising / active-high, 0 = falling / active-low.
    localparam logic              ACT       = (EDGE != 0);
    localparam logic              LATCH     = (MODE != 0);
    localparam logic [WIDTH-1:0]  SET_V     = WIDTH'(SET_VALUE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

        logic [WIDTH-1:0] val;      // stored register value
        logic             c_d;      // previous sampled strobe level
        logic             cs;       // sampled strobe used for detection
        logic             first;    // previous sample was inactive
        logic             active;   // current sample is at the active level
        logic             cap;      // load d at this negedge
        logic             upd_r;    // one-period capture pulse
        logic [WIDTH-1:0] q_ch;     // override-resolved output value

        if (SYNC != 0) begin : g_sync
            logic c_s;

            // Extra sampling stage; reset to the active level so a strobe
            // already active at reset release is not seen as a new edge.
            always_ff @(negedge clock or negedge resb) begin
                if (!resb) begin
                    c_s <= ACT;
                end else begin
                    c_s <= c[i];
                end
            end

            assign cs = c_s;
        end else begin : g_nosync
            assign cs = c[i];
        end

        // Capture decision: edge mode needs an inactive-to-active transition,
        // latch mode loads on every negedge the strobe is active.
        always_comb begin
            first  = (c_d != ACT);
            active = (cs == ACT);
            if (LATCH) begin
                cap = active;
            end else begin
                cap = active && first;
            end
        end

        // Output resolution: reset (and hard reset) force zero, set forces
        // SET_VALUE, otherwise the stored value. Zero latency on overrides.
        always_comb begin
            if (!resb) begin
                q_ch = '0;
            end else if (r[i]) begin
                q_ch = '0;
            end else if (s[i]) begin
                q_ch = SET_V;
            end else begin
                q_ch = val;
            end
        end

        // Per-channel state: capture wins over overrides in storage; without
        // a capture the visible value (including any override) is written back.
        always_ff @(negedge clock or negedge resb) begin
            if (!resb) begin
                val   <= '0;
                c_d   <= ACT;
                upd_r <= 1'b0;
            end else begin
                c_d <= cs;
                if (cap) begin
                    val <= d[i*WIDTH +: WIDTH];
                end else begin
                    val <= q_ch;
                end
                // In latch mode only the first active negedge is flagged.
                upd_r <= cap && first;
            end
        end

        assign q[i*WIDTH +: WIDTH] = q_ch;
        assign upd[i]              = upd_r;
    end

endmodule
